// File: rtl/tile_feeder_if.sv
// Operand-buffer read port and skewer beat bus of tile_feeder.
// master = feeder side, slave = buffer/skewer side.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface tile_feeder_if #(
    parameter int N          = `ARRAY_SIZE,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = 8
);
    logic                    mem_rd_en;
    logic [ADDR_WIDTH-1:0]   mem_rd_addr;
    logic [N*DATA_WIDTH-1:0] mem_rd_data;
    logic                    skew_en;
    logic [DATA_WIDTH-1:0]   data_out [N-1:0];
    logic                    first_out;
    logic                    last_out;
    logic [N*DATA_WIDTH-1:0] data_out_flat;

    modport master (
        output mem_rd_en, mem_rd_addr, skew_en, data_out, first_out, last_out, data_out_flat,
        input  mem_rd_data
    );
    modport slave (
        input  mem_rd_en, mem_rd_addr, skew_en, data_out, first_out, last_out, data_out_flat,
        output mem_rd_data
    );
endinterface

// File: rtl/tile_feeder.sv
// Reads an N-row tile from the operand buffer and streams it to the skewer through a
// 2-entry fall-through FIFO. Optional zero-beat flush: define TILE_FEEDER_DRAIN_EN.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tile_feeder #(
    parameter int N          = `ARRAY_SIZE,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic                  i_stall,
    output logic                  o_busy,
    output logic                  o_done,
    tile_feeder_if.master         bus
);
    localparam int            CW       = $clog2(N + 1);
    localparam int            W        = N * DATA_WIDTH;
    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

`ifdef TILE_FEEDER_DRAIN_EN
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_FIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FIN} state_t;
`endif

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CW-1:0]         r_issued;
`ifdef TILE_FEEDER_DRAIN_EN
    logic [CW-1:0]         r_drain_cnt;
`endif
    logic                  r_in_flight;
    logic                  r_if_first;
    logic                  r_if_last;
    logic [W-1:0]          r_fifo_data  [2];
    logic                  r_fifo_first [2];
    logic                  r_fifo_last  [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [W-1:0]          r_hold_data;

    logic         w_feed;
    logic         w_fifo_nonempty;
    logic         w_head_valid;
    logic [W-1:0] w_head_data;
    logic         w_head_first;
    logic         w_head_last;
    logic         w_data_pop;
    logic         w_drain_beat;
    logic         w_skew_en;
    logic         w_fifo_pop;
    logic         w_push;
    logic [2:0]   w_occ;
    logic         w_rd_en;
    logic [W-1:0] w_data_out;

    assign w_feed          = (r_state == S_FEED);
    assign w_fifo_nonempty = (r_count != 2'd0);

    // Empty FIFO: the returning read bypasses straight to the head, so row k leaves in cycle k+2.
    assign w_head_valid = w_feed & (w_fifo_nonempty | r_in_flight);
    assign w_head_data  = w_fifo_nonempty ? r_fifo_data[r_rd_ptr]  : bus.mem_rd_data;
    assign w_head_first = w_fifo_nonempty ? r_fifo_first[r_rd_ptr] : r_if_first;
    assign w_head_last  = w_fifo_nonempty ? r_fifo_last[r_rd_ptr]  : r_if_last;

    assign w_data_pop = w_head_valid & ~i_stall;
`ifdef TILE_FEEDER_DRAIN_EN
    assign w_drain_beat = (r_state == S_DRAIN) & ~i_stall;
`else
    assign w_drain_beat = 1'b0;
`endif
    assign w_skew_en  = w_data_pop | w_drain_beat;
    assign w_fifo_pop = w_data_pop & w_fifo_nonempty;
    assign w_push     = r_in_flight & (w_fifo_nonempty | ~w_data_pop);

    // Occupancy after this cycle's pop; a new read is only issued if its data will have a slot.
    assign w_occ   = 3'(r_count) + 3'(r_in_flight) - 3'(w_data_pop);
    assign w_rd_en = w_feed & (r_issued < N_CNT) & (w_occ < 3'd2);

    assign w_data_out = w_skew_en ? (w_data_pop ? w_head_data : '0) : r_hold_data;

    assign bus.mem_rd_en     = w_rd_en;
    assign bus.mem_rd_addr   = r_base + ADDR_WIDTH'(r_issued);
    assign bus.skew_en       = w_skew_en;
    assign bus.first_out     = w_data_pop & w_head_first;
    assign bus.last_out      = w_data_pop & w_head_last;
    assign bus.data_out_flat = w_data_out;
    assign o_busy            = r_busy;
    assign o_done            = r_done;

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign bus.data_out[g] = w_data_out[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // NOTE: the FIFO storage is reset too, so data_out never exposes stale rows after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_data  <= '{default: '0};
            r_fifo_first <= '{default: 1'b0};
            r_fifo_last  <= '{default: 1'b0};
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_in_flight  <= 1'b0;
            r_if_first   <= 1'b0;
            r_if_last    <= 1'b0;
            r_hold_data  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= bus.mem_rd_data;
                r_fifo_first[r_wr_ptr] <= r_if_first;
                r_fifo_last[r_wr_ptr]  <= r_if_last;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count     <= r_count + 2'(w_push) - 2'(w_fifo_pop);
            r_in_flight <= w_rd_en;
            r_if_first  <= w_rd_en & (r_issued == '0);
            r_if_last   <= w_rd_en & (r_issued == LAST_CNT);
            if (w_skew_en) r_hold_data <= w_data_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_base      <= '0;
            r_issued    <= '0;
`ifdef TILE_FEEDER_DRAIN_EN
            r_drain_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state  <= S_FEED;
                        r_busy   <= 1'b1;
                        r_base   <= i_base_addr;
                        r_issued <= '0;
                    end
                end
                S_FEED: begin
                    if (w_rd_en) r_issued <= r_issued + CW'(1);
                    if (w_data_pop & w_head_last) begin
`ifdef TILE_FEEDER_DRAIN_EN
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
`else
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
`endif
                    end
                end
`ifdef TILE_FEEDER_DRAIN_EN
                S_DRAIN: begin
                    if (w_drain_beat) begin
                        if (r_drain_cnt == LAST_CNT) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + CW'(1);
                        end
                    end
                end
`endif
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/tile_feeder.md
# tile_feeder

Upstream stage of the streaming skewer. On a `start` pulse it reads an N-row operand tile from the local operand buffer (one row of N lanes per address) and streams it, one row per beat, into the skewer's `data_in`/`en`/`first_in`/`last_in` inputs. Optionally it appends zero beats so the skewer pipeline flushes before `done`. It absorbs downstream stalls with a 2-entry buffer, and no beat is lost or duplicated.

## Interface
- `N`, `` `ARRAY_SIZE ``, rows per tile and lanes per row
- `DATA_WIDTH`, `` `DATA_WIDTH ``, lane width
- `ADDR_WIDTH`, 8, operand buffer address width

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a tile; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  address of row 0; captured on accepted `start`
- `stall`  in  1  downstream cannot accept a beat this cycle
- `busy`  out  1  tile in progress
- `done`  out  1  1-cycle pulse at tile completion
- `mem_rd_en`  out  1  buffer read strobe
- `mem_rd_addr`  out  ADDR_WIDTH  read address
- `mem_rd_data`  in  N*DATA_WIDTH  read data, valid exactly 1 cycle after `mem_rd_en`; lane i = bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `skew_en`  out  1  beat presented and accepted (drives skewer `en`)
- `data_out`  out  [DATA_WIDTH-1:0] x [N-1:0]  beat lanes
- `first_out`  out  1  beat is row 0 (drives `first_in`)
- `last_out`  out  1  beat is row N-1 (drives `last_in`)
- `data_out_flat`  out  N*DATA_WIDTH  `{data_out[N-1],…,data_out[0]}` for Verilator

## Operation
- FSM states:
  - IDLE: `start` is accepted here.
  - FEED: issue N reads at `base_addr + k`, k = 0..N-1.
  - DRAIN: N zero beats; present only with the macro.
  - FIN: asserts `done` for one cycle, then returns to IDLE.
- FEED→DRAIN after the last data beat is accepted. Without the macro, FEED→FIN instead.
- DRAIN→FIN after the N-th drain beat is accepted.
- `start` outside IDLE is ignored. `base_addr` is latched only at accept.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Buffer:
  - Returned read data is pushed into a 2-entry FIFO. The FIFO head drives `data_out`, `first_out` and `last_out`.
  - `skew_en = head_valid & ~stall`; the head pops when `skew_en` is high.
  - When no beat is accepted, `data_out` holds its value and the markers are 0.
- Read issue rule: `mem_rd_en = FEED & rows_issued < N & (fifo_count + in_flight - pop) < 2`. This gives full throughput with no stall and never overflows.
- Markers travel with their row. With N=1, the single beat has `first_out` and `last_out` both high.
- Drain beats carry all-zero lanes and have both markers at 0.
- `busy` is high in every state except IDLE.

## Timing
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, counters 0. The FIFO data registers reset to 0.
- Reset mid-tile aborts immediately: there is no `done` and in-flight read data is discarded.
- Cycle numbering: `start` is sampled at edge 0; cycle c means after edge c.
- Stall-free schedule:
  - `busy` rises in cycle 1.
  - `mem_rd_en` is high in cycles 1..N with addresses base..base+N-1.
  - Row k is presented with `skew_en`=1 in cycle k+2; `first_out` is in cycle 2 and `last_out` in cycle N+1.
  - Drain beats occupy cycles N+2..2N+1.
  - `done` is high in cycle 2N+2. `busy` is low and IDLE is reached in cycle 2N+3.
- A `start` in the same cycle as `done` is ignored. The earliest new start is sampled in the cycle after `done`.
- Each stall cycle delays every later event by exactly 1 cycle. A stall in IDLE or FIN has no effect.

## Configuration
- `TILE_FEEDER_DRAIN_EN`
  - Defined: the DRAIN state emits N zero beats with `skew_en` so the skewer's last marker exits before `done`.
  - Undefined: DRAIN is removed; `done` follows the last data beat by 1 cycle (cycle N+2 when stall-free) and the block never emits zero beats.

## Test plan
- N=4, base=0x10, rows hold lane values 0x11..0x44, no stall, macro on:
  - reads at 0x10..0x13 in cycles 1–4;
  - beats in cycles 2–5 with first in cycle 2 and last in cycle 5;
  - 4 zero beats in cycles 6–9;
  - `done` in cycle 10.
- Same tile with `stall` held in cycles 3–5:
  - `skew_en` low for those cycles;
  - rows arrive in order, with no loss or duplication;
  - `mem_rd_en` drops once the FIFO plus the in-flight read reaches 2;
  - `done` in cycle 13.
- base=0xFE, N=4: read addresses are 0xFE, 0xFF, 0x00, 0x01.
- `start` pulsed in cycle 3 while busy: ignored, and one `done` only. A `start` in the `done` cycle is also ignored.
- `rst_n` low in cycle 4: all outputs 0 asynchronously and no `done`; a fresh start then completes normally.
- Macro off, N=4: `done` in cycle 6, and no zero beats are ever emitted.
